sysarray_skew_feeder: RTL
=========================

SYSARRAY_SKEW_FEEDER -- requirements
Module: sysarray_skew_feeder

Interface
REQ-001 The block SHALL have parameter N, default 8, the array dimension (number of west lanes and number of north lanes).
REQ-002 The block SHALL have parameter DW, default 32, the data width of each lane.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream beat on in_west_vec/in_north_vec is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat on this cycle.
REQ-007 The block SHALL have port in_west_vec, input, N*DW bits: lane i at [i*DW +: DW] carries A[i][k] for beat k.
REQ-008 The block SHALL have port in_north_vec, input, N*DW bits: lane j at [j*DW +: DW] carries B[k][j] for beat k.
REQ-009 The block SHALL have port flush, input, 1 bit: discard the partially loaded frame.
REQ-010 The block SHALL have port out_west, output, N*DW bits: skewed west lane i at [i*DW +: DW], to the array's west edge.
REQ-011 The block SHALL have port out_north, output, N*DW bits: skewed north lane j at [j*DW +: DW], to the array's north edge.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_west/out_north carry stream data.
REQ-013 The block SHALL have port out_first, output, 1 bit: first stream cycle; the array clears its accumulators on it.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last stream cycle.

Function
REQ-015 The block SHALL implement states IDLE, LOAD and STREAM.
REQ-016 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and LOAD and 0 in STREAM.
REQ-017 The block SHALL store beat k (k = 0..N-1, in acceptance order) into a frame buffer of N*N*DW bits for A and the same for B.
REQ-018 Transitions: IDLE->LOAD on accepting beat 0; LOAD->STREAM on accepting beat N-1; STREAM->IDLE after 2N-1 stream cycles.
REQ-019 When N=1, the block SHALL go IDLE->STREAM directly on accepting beat 0.
REQ-020 A cycle with in_valid=0 in IDLE or LOAD SHALL leave the state and beat count unchanged; no bubble reaches the outputs.
REQ-021 In STREAM, stream counter t SHALL advance 0..2N-2, one per cycle, without stalls; in_valid SHALL be ignored.
REQ-022 At stream cycle t, west lane i SHALL output A[i][t-i] when 0 <= t-i <= N-1, else 0.
REQ-023 At stream cycle t, north lane j SHALL output B[t-j][j] when 0 <= t-j <= N-1, else 0.
REQ-024 Outputs SHALL be registered; the first out_valid cycle SHALL be the cycle immediately after the edge that accepted beat N-1.
REQ-025 out_valid SHALL be 1 for exactly 2N-1 consecutive cycles per frame; out_west and out_north SHALL be 0 whenever out_valid=0.
REQ-026 out_first SHALL be 1 only in stream cycle t=0.
REQ-027 frame_done SHALL be 1 for exactly the single cycle following the last stream cycle, in IDLE with in_ready=1; a beat accepted in that cycle SHALL start the next frame.
REQ-028 flush=1 in LOAD SHALL return the block to IDLE with beat count 0 on the next edge; the beat presented on that edge SHALL be discarded.
REQ-029 flush SHALL be ignored in IDLE and STREAM.
REQ-030 Counter widths SHALL be $clog2 of their ranges (N and 2N-1), minimum 1 bit; the block performs no arithmetic on the data.

Reset
REQ-031 While rst=1 at an edge, the block SHALL go to IDLE, clear the beat and stream counters, and set out_valid, out_first, frame_done, out_west and out_north to 0.
REQ-032 in_ready SHALL be 1 in the cycle after reset.
REQ-033 Reset SHALL override flush and any handshake on the same edge.
REQ-034 Reset asserted in LOAD or STREAM SHALL abandon the frame, with outputs zero from the next cycle.
REQ-035 Frame buffer contents need not be reset.

Verification
REQ-036 Scenario 1, N=8: load A[i][k]=8i+k+1 and B[k][j]=8k+j+101, in_valid held high -> out_valid for 15 cycles; t=0: west0=1, north0=101, other lanes 0; t=3: west3=25; t=10: west3=32; t=14: only west7=64 and north7=164 nonzero; frame_done on the next cycle.
REQ-037 Scenario 2: as scenario 1 with in_valid low for 3 cycles between beats 2 and 3 -> identical output sequence; first out_valid cycle is one cycle after beat 7 is accepted.
REQ-038 Scenario 3: two frames back-to-back, the second starting in the frame_done cycle -> second out_first arrives exactly 8 cycles after frame_done; no overlap of frames.
REQ-039 Scenario 4: flush after 4 beats, then a full frame of new data -> output contains only the new data (west0=new A[0][0] at t=0).
REQ-040 Scenario 5: rst at stream t=5 -> all outputs 0 on the next cycle; in_ready=1; no frame_done.
REQ-041 Scenario 6: in_valid=1 throughout STREAM with changing data -> no beat is accepted and the buffered frame is unchanged.

Source files
------------

// File: rtl/sysarray_skew_feeder_if.sv
// Bundle between the upstream beat source and the skew feeder.
// Beat input, flush, and the skewed west/north edge outputs.
interface sysarray_skew_feeder_if #(
    parameter int N  = 8,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [N*DW-1:0] in_west_vec;
    logic [N*DW-1:0] in_north_vec;
    logic          flush;
    logic [N*DW-1:0] out_west;
    logic [N*DW-1:0] out_north;
    logic          out_valid;
    logic          out_first;
    logic          frame_done;

    modport master (
        output in_valid, in_west_vec, in_north_vec, flush,
        input  in_ready, out_west, out_north, out_valid, out_first, frame_done
    );

    modport slave (
        input  in_valid, in_west_vec, in_north_vec, flush,
        output in_ready, out_west, out_north, out_valid, out_first, frame_done
    );
endinterface

// File: rtl/sysarray_skew_feeder.sv
// Buffers an N-beat A/B frame, then streams it diagonally skewed onto the
// west and north edges of an NxN systolic array over 2N-1 cycles.
module sysarray_skew_feeder #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic rst,
    sysarray_skew_feeder_if.slave bus
);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (N > 1) ? $clog2(2 * N - 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
    localparam logic [TW-1:0] LAST_T    = TW'(2 * N - 2);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   beat_reg, beat_next;
    logic [TW-1:0]   t_reg, t_next;
    logic            in_ready;
    logic            accept;
    logic            store;
    logic            out_valid_reg, out_first_reg, frame_done_reg;

    assign in_ready = (state_reg != STREAM);
    assign accept   = bus.in_valid && in_ready;
    // A flushed beat is dropped even though the handshake completes.
    assign store    = accept && !(state_reg == LOAD && bus.flush);

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_first  = out_first_reg;
    assign bus.frame_done = frame_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            beat_reg       <= '0;
            t_reg          <= '0;
            out_valid_reg  <= 1'b0;
            out_first_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            t_reg          <= t_next;
            out_valid_reg  <= (state_next == STREAM);
            out_first_reg  <= (state_reg != STREAM) && (state_next == STREAM);
            frame_done_reg <= (state_reg == STREAM) && (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        t_next     = t_reg;
        case (state_reg)
            IDLE, LOAD: begin
                if (state_reg == LOAD && bus.flush) begin
                    state_next = IDLE;
                    beat_next  = '0;
                end else if (store) begin
                    if (beat_reg == LAST_BEAT) begin
                        state_next = STREAM;
                        beat_next  = '0;
                        t_next     = '0;
                    end else begin
                        state_next = LOAD;
                        beat_next  = beat_reg + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (t_reg == LAST_T) begin
                    state_next = IDLE;
                    t_next     = '0;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output registers are loaded with the value for the upcoming stream cycle,
    // so out_valid appears the cycle right after the last beat is accepted.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_row [N];
        logic [DW-1:0] b_col [N];
        logic [DW-1:0] west_next, north_next;
        logic [DW-1:0] west_reg, north_reg;
        logic [TW-1:0] dt;
        logic [BW-1:0] k;
        logic          in_window;
        logic          bypass;

        always_ff @(posedge clk) begin
            if (store) begin
                a_row[beat_reg] <= bus.in_west_vec[gi*DW +: DW];
                b_col[beat_reg] <= bus.in_north_vec[gi*DW +: DW];
            end
        end

        always_comb begin
            dt         = t_next - TW'(gi);
            k          = BW'(dt);
            in_window  = (state_next == STREAM) && (t_next >= TW'(gi)) && (dt <= TW'(N - 1));
            // Only reachable for N=1, where the frame's sole beat streams immediately.
            bypass     = store && (k == beat_reg);
            west_next  = '0;
            north_next = '0;
            if (in_window) begin
                west_next  = bypass ? bus.in_west_vec[gi*DW +: DW]  : a_row[k];
                north_next = bypass ? bus.in_north_vec[gi*DW +: DW] : b_col[k];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                west_reg  <= '0;
                north_reg <= '0;
            end else begin
                west_reg  <= west_next;
                north_reg <= north_next;
            end
        end

        assign bus.out_west[gi*DW +: DW]  = west_reg;
        assign bus.out_north[gi*DW +: DW] = north_reg;
    end
endmodule
